// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with a valid/ready handshake, an optional skid entry,
// multi-source flush with hold-safe capture, flush cause and a saturating flush count.
module pipe_stage_reg #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned FLUSH_N     = 7,
   parameter bit          SKID_EN     = 1'b1,
   parameter bit          ZERO_BUBBLE = 1'b1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic [FLUSH_N-1:0] flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [1:0]         occupancy,
   output logic               flush_pending,
   output logic [FLUSH_N-1:0] flush_src,
   output logic [CNT_W-1:0]   flush_cnt
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  main_q, main_d;
   logic [DATA_W-1:0]  skid_q, skid_d;
   logic [FLUSH_N-1:0] pend_q, pend_d;
   logic [FLUSH_N-1:0] src_q, src_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic valid_w;
   logic accept;
   logic pop;
   logic flush_eff;

   // Handshake events and the effective flush decision.
   always_comb begin
      valid_w = (state_q != StEmpty);
      if (SKID_EN) begin
         // Registered state only, so in_ready never depends on out_ready.
         in_ready = !hold && (state_q != StTwo);
      end else begin
         in_ready = !hold && (!valid_w || out_ready);
      end
      accept    = in_valid && in_ready;
      pop       = valid_w && out_ready && !hold;
      flush_eff = ((|flush) || (|pend_q)) && !hold;
   end

   // Next-state logic: hold freezes all storage, flush empties the stage, otherwise FIFO moves.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      pend_d  = pend_q;
      src_d   = src_q;
      cnt_d   = cnt_q;

      if (hold) begin
         // Flush requests seen while frozen are remembered and applied on release.
         pend_d = pend_q | flush;
      end else if (flush_eff) begin
         // Same-cycle accept is discarded; a same-cycle pop has already completed downstream.
         state_d = StEmpty;
         pend_d  = '0;
         src_d   = flush | pend_q;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  main_d  = in_data;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (accept && pop) begin
                  main_d = in_data;
               end else if (pop) begin
                  state_d = StEmpty;
               end else if (accept && SKID_EN) begin
                  skid_d  = in_data;
                  state_d = StTwo;
               end
            end
            StTwo: begin
               if (pop) begin
                  main_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: begin
               state_d = StEmpty;
            end
         endcase
      end
   end

   // State and storage registers with synchronous reset taking priority over hold and flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         main_q  <= '0;
         skid_q  <= '0;
         pend_q  <= '0;
         src_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         pend_q  <= pend_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output drive: bubble is zeroed when enabled, otherwise the last main value is shown.
   always_comb begin
      out_valid = valid_w;
      if (valid_w || !ZERO_BUBBLE) begin
         out_data = main_q;
      end else begin
         out_data = '0;
      end
      unique case (state_q)
         StEmpty: occupancy = 2'd0;
         StOne:   occupancy = 2'd1;
         StTwo:   occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
      flush_pending = |pend_q;
      flush_src     = src_q;
      flush_cnt     = cnt_q;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-boundary register for the CPU datapath (ID/EXE, EXE/MEM, etc.) that generalises the fixed stall/flush register.
- Payload width is configurable. It supports a valid/ready handshake, an optional one-entry skid buffer that breaks the ready path, and an N-source flush vector.
- Flushes arriving during a global hold are remembered and applied on release, not lost. The block also reports flush cause and a flush count.

Parameters:
- DATA_W, 32, payload width in bits (pc, operands, imm, inst concatenated by the parent).
- FLUSH_N, 7, number of independent flush sources (branch redirect, wfi, intr entry/exit, mispredict types, load-use bubble).
- SKID_EN, 1, 1 = two-entry (main + skid) storage with registered in_ready; 0 = single entry.
- ZERO_BUBBLE, 1, 1 = out_data forced to all-zero whenever out_valid=0 (NOP bubble); 0 = out_data holds last value.
- CNT_W, 16, width of the saturating flush counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hold  in  1  global freeze (IF/memory stall); overrides everything except rst
- flush  in  FLUSH_N  per-source flush requests
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload to next stage
- occupancy  out  2  entries held (0..1+SKID_EN)
- flush_pending  out  1  flush captured during hold, not yet applied
- flush_src  out  FLUSH_N  OR of sources of the most recent applied flush
- flush_cnt  out  CNT_W  number of applied flushes, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - occupancy=0, out_valid=0, out_data=0, flush_pending=0, flush_src=0, flush_cnt=0, all storage 0.
  - rst has priority over hold and flush.
- States:
  - EMPTY (0 entries).
  - ONE (main valid).
  - TWO (main+skid valid). TWO is reachable only if SKID_EN=1.
- in_ready:
  - SKID_EN=1: `!hold && occupancy<2`. Registered state only; no combinational path from out_ready.
  - SKID_EN=0: `!hold && (!out_valid || out_ready)`.
- Events:
  - accept = in_valid && in_ready.
  - pop = out_valid && out_ready && !hold.
- hold=1:
  - All data and state registers freeze; no accept, no pop.
  - flush bits OR into an internal pending vector; flush_pending=1 if any bit is set.
  - out_valid and out_data stay stable.
- Effective flush = (|flush || flush_pending) && !hold.
  - Next cycle: occupancy=0, out_valid=0; the same-cycle accept is discarded and any pop completes.
  - flush_src <= flush | pending vector.
  - flush_cnt <= flush_cnt+1, saturating at all-ones.
  - Pending vector and flush_pending are cleared.
- Without flush and hold:
  - EMPTY: accept -> ONE.
  - ONE: accept&pop -> ONE (new data); pop only -> EMPTY; accept only -> TWO (SKID_EN=1).
  - TWO: pop -> ONE, skid entry moves to main. Order is strictly FIFO.
  - Latency is 1 cycle from accept into EMPTY to out_valid.
- out_data: main entry when out_valid=1; otherwise all-zero if ZERO_BUBBLE=1, else the last main value.
- No beat is duplicated or dropped except on an effective flush.

Test Plan:
- Reset, then in_valid=1 with in_data=0x00000013, out_ready=1 -> out_valid=1 and out_data=0x00000013 one cycle later; occupancy=1.
- SKID_EN=1, out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0. Then out_ready=1 -> out_data 0xA, then 0xB, in order, with no loss.
- flush[2]=1 while in_valid=1 with in_data=0xC -> next cycle out_valid=0, out_data=0, flush_src=0x04, flush_cnt=1, 0xC dropped.
- hold=1 for 3 cycles with flush[0] pulsed in cycle 1 and flush[5] in cycle 2:
  - During hold: outputs frozen, flush_pending=1.
  - One cycle after hold deasserts: the flush applies, flush_src=0x21, flush_cnt increments by 1.
- hold=1 with out_ready=1 and out_valid=1 -> no pop; out_data unchanged until hold=0.
- Preload flush_cnt to all-ones via repeated flushes (CNT_W=4) -> stays at 0xF on the 16th and later flushes. Then rst mid-TWO -> all outputs zero on the next edge.
